// File: rtl/program_loader_if.sv
// Bundled stream, code-RAM, calc and result signals of the program loader.
// slave is the loader's view; master is the view of whatever surrounds it.
interface program_loader_if #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 16
) ();
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_wr;
  logic [DATA_W-1:0] mem_data;
  logic              calc_start;
  logic              calc_ready;
  logic [DATA_W-1:0] calc_out;
  logic [DATA_W-1:0] result;
  logic              result_valid;
  logic              result_ack;
  logic              timeout;
  logic              err_len;

  modport slave (
    input  in_valid, in_data, calc_ready, calc_out, result_ack,
    output in_ready, mem_addr, mem_wr, mem_data, calc_start,
           result, result_valid, timeout, err_len
  );

  modport master (
    output in_valid, in_data, calc_ready, calc_out, result_ack,
    input  in_ready, mem_addr, mem_wr, mem_data, calc_start,
           result, result_valid, timeout, err_len
  );
endinterface

// File: rtl/program_loader.sv
// Loads a length-prefixed program into the stack machine's code RAM, starts it,
// and hands back the top-of-stack result (or a watchdog timeout) via valid/ack.
module program_loader #(
  parameter int ADDR_W     = 10,
  parameter int DATA_W     = 16,
  parameter int MAX_CYCLES = 65535
) (
  input  logic             clk,
  input  logic             rst,
  program_loader_if.slave  bus
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LOAD  = 3'd1;
  localparam logic [2:0] S_START = 3'd2;
  localparam logic [2:0] S_WAIT  = 3'd3;
  localparam logic [2:0] S_RUN   = 3'd4;
  localparam logic [2:0] S_DONE  = 3'd5;

  localparam int              CYC_W    = $clog2(MAX_CYCLES);
  localparam logic [CYC_W-1:0] CYC_LAST = CYC_W'(MAX_CYCLES - 1);
  localparam logic [ADDR_W:0]  LEN_MAX  = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0]  LEN_ONE  = {{ADDR_W{1'b0}}, 1'b1};

  logic [2:0]        state_q, state_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic [ADDR_W:0]   len_q, len_d;
  logic [CYC_W-1:0]  cyc_q, cyc_d;
  logic [1:0]        wait_q, wait_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_data_q, mem_data_d;
  logic              mem_wr_q, mem_wr_d;
  logic              calc_start_q, calc_start_d;
  logic [DATA_W-1:0] result_q, result_d;
  logic              result_valid_q, result_valid_d;
  logic              timeout_q, timeout_d;
  logic              err_len_q, err_len_d;

  logic              in_ready;
  logic              accept;
  logic [ADDR_W:0]   hdr_len;

  assign in_ready = (state_q == S_IDLE) || (state_q == S_LOAD);
  assign accept   = bus.in_valid && in_ready;
  assign hdr_len  = bus.in_data[ADDR_W:0];

  always_comb begin
    state_d        = state_q;
    idx_d          = idx_q;
    len_d          = len_q;
    cyc_d          = cyc_q;
    wait_d         = wait_q;
    mem_addr_d     = mem_addr_q;
    mem_data_d     = mem_data_q;
    mem_wr_d       = 1'b0;
    calc_start_d   = 1'b0;
    result_d       = result_q;
    result_valid_d = result_valid_q;
    timeout_d      = timeout_q;
    err_len_d      = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (hdr_len == '0 || hdr_len > LEN_MAX) begin
            err_len_d = 1'b1;
          end else begin
            len_d   = hdr_len;
            idx_d   = '0;
            state_d = S_LOAD;
          end
        end
      end
      S_LOAD: begin
        if (accept) begin
          mem_addr_d = idx_q;
          mem_data_d = bus.in_data;
          mem_wr_d   = 1'b1;
          idx_d      = idx_q + ADDR_W'(1);
          if ({1'b0, idx_q} == len_q - LEN_ONE) begin
            state_d = S_START;
          end
        end
      end
      S_START: begin
        calc_start_d = 1'b1;
        wait_d       = '0;
        state_d      = S_WAIT;
      end
      S_WAIT: begin
        // A calc that never drops ready is taken as having finished instantly.
        if (!bus.calc_ready) begin
          cyc_d   = '0;
          state_d = S_RUN;
        end else if (wait_q == 2'd3) begin
          result_d       = bus.calc_out;
          result_valid_d = 1'b1;
          timeout_d      = 1'b0;
          state_d        = S_DONE;
        end else begin
          wait_d = wait_q + 2'd1;
        end
      end
      S_RUN: begin
        cyc_d = cyc_q + CYC_W'(1);
        if (bus.calc_ready) begin
          result_d       = bus.calc_out;
          result_valid_d = 1'b1;
          timeout_d      = 1'b0;
          state_d        = S_DONE;
        end else if (cyc_q == CYC_LAST) begin
          result_d       = bus.calc_out;
          result_valid_d = 1'b1;
          timeout_d      = 1'b1;
          state_d        = S_DONE;
        end
      end
      S_DONE: begin
        if (bus.result_ack && result_valid_q) begin
          result_valid_d = 1'b0;
          timeout_d      = 1'b0;
          state_d        = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= S_IDLE;
      idx_q          <= '0;
      len_q          <= '0;
      cyc_q          <= '0;
      wait_q         <= '0;
      mem_addr_q     <= '0;
      mem_data_q     <= '0;
      mem_wr_q       <= 1'b0;
      calc_start_q   <= 1'b0;
      result_q       <= '0;
      result_valid_q <= 1'b0;
      timeout_q      <= 1'b0;
      err_len_q      <= 1'b0;
    end else begin
      state_q        <= state_d;
      idx_q          <= idx_d;
      len_q          <= len_d;
      cyc_q          <= cyc_d;
      wait_q         <= wait_d;
      mem_addr_q     <= mem_addr_d;
      mem_data_q     <= mem_data_d;
      mem_wr_q       <= mem_wr_d;
      calc_start_q   <= calc_start_d;
      result_q       <= result_d;
      result_valid_q <= result_valid_d;
      timeout_q      <= timeout_d;
      err_len_q      <= err_len_d;
    end
  end

  assign bus.in_ready     = in_ready;
  assign bus.mem_addr     = mem_addr_q;
  assign bus.mem_data     = mem_data_q;
  assign bus.mem_wr       = mem_wr_q;
  assign bus.calc_start   = calc_start_q;
  assign bus.result       = result_q;
  assign bus.result_valid = result_valid_q;
  assign bus.timeout      = timeout_q;
  assign bus.err_len      = err_len_q;

endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader driving a tiny behavioural stack machine
// (push imm / add / jump-to-self / end) as the code RAM + calc toplevel.
module tb_program_loader;

  logic clk = 1'b0;
  logic rst;
  logic mrst;

  always #5 clk = ~clk;

  program_loader_if #(.ADDR_W(10), .DATA_W(16)) bus ();

  program_loader #(.ADDR_W(10), .DATA_W(16), .MAX_CYCLES(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Stack machine: 00/01 push imm, 10..2 add, 10..7 jump to self, 11 end
  logic [15:0] ram [0:1023];
  logic [15:0] stk [0:7];
  logic [2:0]  sp;
  logic [9:0]  pc;
  logic        busy;
  logic        m_ready;

  always @(posedge clk) begin
    if (mrst) begin
      ram[3]  <= 16'hC000;
      m_ready <= 1'b1;
      busy    <= 1'b0;
      sp      <= '0;
      pc      <= '0;
    end else begin
      if (bus.mem_wr) ram[bus.mem_addr] <= bus.mem_data;
      if (bus.calc_start) begin
        busy    <= 1'b1;
        m_ready <= 1'b0;
        pc      <= '0;
        sp      <= '0;
      end else if (busy) begin
        case (ram[pc][15:14])
          2'b00, 2'b01: begin
            stk[sp] <= ram[pc];
            sp      <= sp + 3'd1;
            pc      <= pc + 10'd1;
          end
          2'b10: begin
            if (ram[pc][3:0] == 4'h2) begin
              stk[sp-3'd2] <= stk[sp-3'd2] + stk[sp-3'd1];
              sp           <= sp - 3'd1;
              pc           <= pc + 10'd1;
            end
          end
          default: begin
            busy    <= 1'b0;
            m_ready <= 1'b1;
          end
        endcase
      end
    end
  end

  assign bus.calc_ready = m_ready;
  assign bus.calc_out   = stk[sp-3'd1];

  logic [9:0]  wa [$];
  logic [15:0] wd [$];
  int starts = 0;
  int errs   = 0;

  always @(negedge clk) begin
    if (bus.mem_wr) begin
      wa.push_back(bus.mem_addr);
      wd.push_back(bus.mem_data);
    end
    if (bus.calc_start) starts++;
    if (bus.err_len) errs++;
  end

  int errors = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [15:0] w);
    int n = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = w;
    while (!bus.in_ready && n < 64) begin
      @(negedge clk);
      n++;
    end
    if (!bus.in_ready) chk("send_ready", {31'b0, bus.in_ready}, 32'd1);
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    while (!bus.result_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("valid_seen", {31'b0, bus.result_valid}, 32'd1);
  endtask

  task automatic ack_and_check(input string tag);
    bus.result_ack = 1'b1;
    @(negedge clk);
    bus.result_ack = 1'b0;
    chk({tag, "_valid_clr"}, {31'b0, bus.result_valid}, 32'd0);
    chk({tag, "_idle"}, {31'b0, bus.in_ready}, 32'd1);
  endtask

  logic [15:0] p1 [3] = '{16'h0005, 16'h0007, 16'h8002};
  logic [15:0] p3 [4] = '{16'h0001, 16'h0002, 16'h8002, 16'hC000};
  logic [15:0] p6 [3] = '{16'h0004, 16'h0006, 16'h8002};

  initial begin
    int n;
    int wb;
    int sb;
    int eb;

    rst = 1'b1;
    mrst = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_data = '0;
    bus.result_ack = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_in_ready", {31'b0, bus.in_ready}, 32'd1);
    chk("rst_mem_wr", {31'b0, bus.mem_wr}, 32'd0);
    chk("rst_mem_addr", {22'b0, bus.mem_addr}, 32'd0);
    chk("rst_start", {31'b0, bus.calc_start}, 32'd0);
    chk("rst_valid", {31'b0, bus.result_valid}, 32'd0);
    chk("rst_result", {16'b0, bus.result}, 32'd0);
    chk("rst_timeout", {31'b0, bus.timeout}, 32'd0);
    chk("rst_err_len", {31'b0, bus.err_len}, 32'd0);
    rst = 1'b0;
    mrst = 1'b0;
    @(negedge clk);

    // push 5, push 7, add; RAM[3] already holds end
    wb = wa.size();
    sb = starts;
    send(16'd3);
    for (int i = 0; i < 3; i++) send(p1[i]);
    wait_valid(n);
    chk("t1_result", {16'b0, bus.result}, 32'd12);
    chk("t1_timeout", {31'b0, bus.timeout}, 32'd0);
    chk("t1_busy_ready", {31'b0, bus.in_ready}, 32'd0);
    chk("t1_wr_count", wa.size() - wb, 32'd3);
    for (int i = 0; i < 3; i++) begin
      if (wb + i < wa.size()) begin
        chk("t1_addr", {22'b0, wa[wb+i]}, i);
        chk("t1_data", {16'b0, wd[wb+i]}, {16'b0, p1[i]});
      end
    end
    chk("t1_starts", starts - sb, 32'd1);
    ack_and_check("t1");

    // rejected headers: 0, 2000, and one past the maximum
    wb = wa.size();
    eb = errs;
    send(16'd0);
    chk("t2_err0", {31'b0, bus.err_len}, 32'd1);
    chk("t2_ready0", {31'b0, bus.in_ready}, 32'd1);
    send(16'd2000);
    chk("t2_err2000", {31'b0, bus.err_len}, 32'd1);
    send(16'd1025);
    chk("t2_err1025", {31'b0, bus.err_len}, 32'd1);
    @(negedge clk);
    chk("t2_err_clr", {31'b0, bus.err_len}, 32'd0);
    chk("t2_ready", {31'b0, bus.in_ready}, 32'd1);
    repeat (2) @(negedge clk);
    chk("t2_err_count", errs - eb, 32'd3);
    chk("t2_no_wr", wa.size() - wb, 32'd0);

    // gapped in_valid during a 4-word load, then ack withheld
    wb = wa.size();
    send(16'd4);
    send(p3[0]);
    @(negedge clk);
    send(p3[1]);
    repeat (2) @(negedge clk);
    send(p3[2]);
    @(negedge clk);
    send(p3[3]);
    wait_valid(n);
    chk("t3_result", {16'b0, bus.result}, 32'd3);
    chk("t3_timeout", {31'b0, bus.timeout}, 32'd0);
    chk("t3_wr_count", wa.size() - wb, 32'd4);
    for (int i = 0; i < 4; i++) begin
      if (wb + i < wa.size()) begin
        chk("t3_addr", {22'b0, wa[wb+i]}, i);
        chk("t3_data", {16'b0, wd[wb+i]}, {16'b0, p3[i]});
      end
    end
    repeat (10) @(negedge clk);
    chk("t5_result_hold", {16'b0, bus.result}, 32'd3);
    chk("t5_valid_hold", {31'b0, bus.result_valid}, 32'd1);
    chk("t5_in_ready", {31'b0, bus.in_ready}, 32'd0);
    ack_and_check("t5");

    // jump-to-self program hits the 8-cycle watchdog
    sb = starts;
    send(16'd1);
    send(16'h8007);
    n = 0;
    while (!bus.calc_start && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("t4_start", {31'b0, bus.calc_start}, 32'd1);
    n = 0;
    while (!bus.result_valid && n < 50) begin
      @(negedge clk);
      n++;
      if (n == 1) chk("t4_start_width", {31'b0, bus.calc_start}, 32'd0);
    end
    chk("t4_latency", n, 32'd10);
    chk("t4_timeout", {31'b0, bus.timeout}, 32'd1);
    chk("t4_valid", {31'b0, bus.result_valid}, 32'd1);
    chk("t4_starts", starts - sb, 32'd1);
    ack_and_check("t4");
    chk("t4_timeout_clr", {31'b0, bus.timeout}, 32'd0);

    // asynchronous reset after the second word of a 4-word packet
    send(16'd4);
    send(16'h0009);
    send(16'h000A);
    chk("t6_pre_wr", {31'b0, bus.mem_wr}, 32'd1);
    rst = 1'b1;
    #1;
    chk("t6_rst_wr", {31'b0, bus.mem_wr}, 32'd0);
    chk("t6_rst_addr", {22'b0, bus.mem_addr}, 32'd0);
    chk("t6_rst_data", {16'b0, bus.mem_data}, 32'd0);
    chk("t6_rst_ready", {31'b0, bus.in_ready}, 32'd1);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    wb = wa.size();
    send(16'd3);
    for (int i = 0; i < 3; i++) send(p6[i]);
    wait_valid(n);
    chk("t6_result", {16'b0, bus.result}, 32'd10);
    chk("t6_timeout", {31'b0, bus.timeout}, 32'd0);
    chk("t6_wr_count", wa.size() - wb, 32'd3);
    for (int i = 0; i < 3; i++) begin
      if (wb + i < wa.size()) begin
        chk("t6_addr", {22'b0, wa[wb+i]}, i);
        chk("t6_data", {16'b0, wd[wb+i]}, {16'b0, p6[i]});
      end
    end
    ack_and_check("t6");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
